seq_mul_dot_acc: RTL and testbench

Downstream consumer of the sequential 4x4 multiplier. It takes each 8-bit product as the multiplier finishes it and accumulates N_TERMS consecutive products into a saturating dot-product sum. It presents each completed sum on a one-deep valid/ready output register. While that register is occupied, it backpressures the multiplier's start logic through `prod_ready`.

---
 rtl/seq_mul_dot_acc.sv | 102 ++++++++++
 tb/tb_seq_mul_dot_acc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_dot_acc.sv
// Saturating dot-product accumulator fed by the sequential 4x4 multiplier.
// Sums N_TERMS products and presents each result on a one-deep valid/ready register.
module seq_mul_dot_acc #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             prod_valid,
  input  logic [7:0]       prod_data,
  output logic             prod_ready,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum_data,
  output logic             sum_sat,
  output logic [3:0]       term_idx
);

  localparam logic [3:0] LastIdx = 4'(N_TERMS - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_sat_q, acc_sat_d;
  logic [3:0]       idx_q, idx_d;
  logic             sum_valid_q, sum_valid_d;
  logic [ACC_W-1:0] sum_data_q, sum_data_d;
  logic             sum_sat_q, sum_sat_d;

  logic             is_last;
  logic             out_free;
  logic             accept;
  logic [ACC_W:0]   raw;
  logic [ACC_W-1:0] nxt;
  logic             nxt_sat;

  // One extra bit catches the carry that triggers clamping.
  assign raw     = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, prod_data};
  assign nxt     = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
  assign nxt_sat = raw[ACC_W] | acc_sat_q;

  assign is_last    = (idx_q == LastIdx);
  assign out_free   = !sum_valid_q || sum_ready;
  // Only the final term needs the output slot; earlier terms flow regardless.
  assign prod_ready = !clear && !(is_last && !out_free);
  assign accept     = prod_valid && prod_ready;

  always_comb begin
    acc_d       = acc_q;
    acc_sat_d   = acc_sat_q;
    idx_d       = idx_q;
    sum_valid_d = sum_valid_q;
    sum_data_d  = sum_data_q;
    sum_sat_d   = sum_sat_q;

    if (sum_valid_q && sum_ready) begin
      sum_valid_d = 1'b0;
    end

    if (clear) begin
      acc_d     = '0;
      acc_sat_d = 1'b0;
      idx_d     = '0;
    end else if (accept) begin
      if (is_last) begin
        sum_data_d  = nxt;
        sum_sat_d   = nxt_sat;
        sum_valid_d = 1'b1;
        acc_d       = '0;
        acc_sat_d   = 1'b0;
        idx_d       = '0;
      end else begin
        acc_d     = nxt;
        acc_sat_d = nxt_sat;
        idx_d     = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      acc_sat_q   <= 1'b0;
      idx_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      sum_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_sat_q   <= acc_sat_d;
      idx_q       <= idx_d;
      sum_valid_q <= sum_valid_d;
      sum_data_q  <= sum_data_d;
      sum_sat_q   <= sum_sat_d;
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum_data  = sum_data_q;
  assign sum_sat   = sum_sat_q;
  assign term_idx  = idx_q;

endmodule

// File: tb/tb_seq_mul_dot_acc.sv
// Directed bench for seq_mul_dot_acc: a default instance plus a 9-bit instance
// sharing the same stimulus, the latter used for the saturation vectors.
module tb_seq_mul_dot_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        prod_valid = 1'b0;
  logic [7:0]  prod_data = '0;
  logic        sum_ready = 1'b0;

  logic        prod_ready;
  logic        sum_valid;
  logic [15:0] sum_data;
  logic        sum_sat;
  logic [3:0]  term_idx;

  logic        s_prod_ready;
  logic        s_sum_valid;
  logic [8:0]  s_sum_data;
  logic        s_sum_sat;
  logic [3:0]  s_term_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mul_dot_acc u_dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_data   (sum_data),
    .sum_sat    (sum_sat),
    .term_idx   (term_idx)
  );

  seq_mul_dot_acc #(
    .N_TERMS (4),
    .ACC_W   (9)
  ) u_sat (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (s_prod_ready),
    .sum_valid  (s_sum_valid),
    .sum_ready  (sum_ready),
    .sum_data   (s_sum_data),
    .sum_sat    (s_sum_sat),
    .term_idx   (s_term_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    prod_valid = 1'b1;
    prod_data  = d;
    tick();
    prod_valid = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(sum_valid), 0);
    chk("rst_data", 32'(sum_data), 0);
    chk("rst_sat", 32'(sum_sat), 0);
    chk("rst_idx", 32'(term_idx), 0);
    chk("rst_ready", 32'(prod_ready), 1);

    // Basic sum 15+49+225+18 = 307
    sum_ready = 1'b1;
    chk("basic_idx0", 32'(term_idx), 0);
    send(8'd15);
    chk("basic_idx1", 32'(term_idx), 1);
    send(8'd49);
    chk("basic_idx2", 32'(term_idx), 2);
    send(8'd225);
    chk("basic_idx3", 32'(term_idx), 3);
    send(8'd18);
    chk("basic_valid", 32'(sum_valid), 1);
    chk("basic_data", 32'(sum_data), 307);
    chk("basic_sat", 32'(sum_sat), 0);
    chk("basic_idx_wrap", 32'(term_idx), 0);
    tick();
    chk("basic_drain", 32'(sum_valid), 0);

    // Saturation on the 9-bit instance: clamps to 511
    send(8'd225);
    send(8'd225);
    send(8'd225);
    send(8'd10);
    chk("sat_valid", 32'(s_sum_valid), 1);
    chk("sat_data", 32'(s_sum_data), 511);
    chk("sat_flag", 32'(s_sum_sat), 1);
    chk("nosat_wide_data", 32'(sum_data), 685);
    chk("nosat_wide_flag", 32'(sum_sat), 0);
    send(8'd1);
    send(8'd1);
    send(8'd1);
    send(8'd1);
    chk("sat_next_data", 32'(s_sum_data), 4);
    chk("sat_next_flag", 32'(s_sum_sat), 0);

    // Backpressure
    tick();
    chk("bp_drained", 32'(sum_valid), 0);
    sum_ready = 1'b0;
    send(8'd1);
    send(8'd2);
    send(8'd3);
    send(8'd4);
    chk("bp_first_valid", 32'(sum_valid), 1);
    chk("bp_first_data", 32'(sum_data), 10);
    send(8'd5);
    send(8'd6);
    send(8'd7);
    chk("bp_idx3", 32'(term_idx), 3);
    prod_valid = 1'b1;
    prod_data  = 8'd8;
    #1;
    chk("bp_ready_low", 32'(prod_ready), 0);
    tick();
    chk("bp_hold_data", 32'(sum_data), 10);
    chk("bp_hold_idx", 32'(term_idx), 3);
    chk("bp_hold_valid", 32'(sum_valid), 1);
    sum_ready = 1'b1;
    #1;
    chk("bp_ready_release", 32'(prod_ready), 1);
    tick();
    prod_valid = 1'b0;
    chk("bp_second_valid", 32'(sum_valid), 1);
    chk("bp_second_data", 32'(sum_data), 26);
    chk("bp_second_idx", 32'(term_idx), 0);

    // Back-to-back vectors of 100
    for (int i = 0; i < 8; i++) begin
      prod_valid = 1'b1;
      prod_data  = 8'd100;
      #1;
      chk("b2b_ready", 32'(prod_ready), 1);
      tick();
      if (i == 3 || i == 7) begin
        chk("b2b_valid", 32'(sum_valid), 1);
        chk("b2b_data", 32'(sum_data), 400);
      end
      if (i == 4) chk("b2b_gap", 32'(sum_valid), 0);
    end
    prod_valid = 1'b0;

    // Clear mid-vector with a pending sum
    sum_ready = 1'b0;
    send(8'd50);
    send(8'd60);
    clear      = 1'b1;
    prod_valid = 1'b1;
    prod_data  = 8'd70;
    #1;
    chk("clr_ready_low", 32'(prod_ready), 0);
    tick();
    clear      = 1'b0;
    prod_valid = 1'b0;
    chk("clr_idx", 32'(term_idx), 0);
    chk("clr_pending_valid", 32'(sum_valid), 1);
    chk("clr_pending_data", 32'(sum_data), 400);
    sum_ready = 1'b1;
    send(8'd1);
    send(8'd2);
    send(8'd3);
    send(8'd4);
    chk("clr_sum_valid", 32'(sum_valid), 1);
    chk("clr_sum_data", 32'(sum_data), 10);

    // Reset mid-operation with pending sum and term_idx 2
    sum_ready = 1'b0;
    send(8'd9);
    send(8'd9);
    chk("rst2_pre_idx", 32'(term_idx), 2);
    chk("rst2_pre_valid", 32'(sum_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_valid", 32'(sum_valid), 0);
    chk("rst2_data", 32'(sum_data), 0);
    chk("rst2_sat", 32'(sum_sat), 0);
    chk("rst2_idx", 32'(term_idx), 0);
    chk("rst2_ready", 32'(prod_ready), 1);
    sum_ready = 1'b1;
    send(8'd2);
    send(8'd2);
    send(8'd2);
    send(8'd2);
    chk("rst2_sum_valid", 32'(sum_valid), 1);
    chk("rst2_sum_data", 32'(sum_data), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
